instruction_decode: RTL and testbench

// Decode stage of the 5-stage RV32I pipeline. Sits between instruction_fetch and execute.

---
 rtl/instruction_decode.sv | 184 ++++++++++++++++++
 tb/tb_instruction_decode.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// RV32I decode stage: register file with write-through bypass, main/ALU decoders,
// immediate extension and the ID/EX pipeline register (bubble on reset or FlushE).
module instruction_decode #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instrD,
    input  logic [WORD_WIDTH-1:0] PCD,
    input  logic [WORD_WIDTH-1:0] PCPlus4D,
    input  logic                  FlushE,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [WORD_WIDTH-1:0] ResultW,
    output logic [4:0]            Rs1D,
    output logic [4:0]            Rs2D,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic                  IllegalE,
    output logic [1:0]            ResultSrcE,
    output logic [2:0]            ALUControlE,
    output logic [WORD_WIDTH-1:0] RD1E,
    output logic [WORD_WIDTH-1:0] RD2E,
    output logic [WORD_WIDTH-1:0] ImmExtE,
    output logic [WORD_WIDTH-1:0] PCE,
    output logic [WORD_WIDTH-1:0] PCPlus4E,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE
);

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic                  illegal;
        logic [1:0]            result_src;
        logic [2:0]            alu_control;
        logic [WORD_WIDTH-1:0] rd1;
        logic [WORD_WIDTH-1:0] rd2;
        logic [WORD_WIDTH-1:0] imm;
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] pc4;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
    } idex_t;

    logic [WORD_WIDTH-1:0] rf_q [32];
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] rd1, rd2, imm;
    logic                  reg_write, mem_write, jump, branch, alu_src, illegal;
    logic [1:0]            result_src, alu_op;
    logic [2:0]            alu_control;
    imm_src_t              imm_src;
    idex_t                 idex_d, idex_q;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign Rs1D   = instrD[19:15];
    assign Rs2D   = instrD[24:20];
    assign wr_en  = RegWriteW && (RdW != 5'd0);

    // Entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // Same-cycle writeback is forwarded so the reader never sees stale data.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (Rs1D != 5'd0) rd1 = (wr_en && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
        if (Rs2D != 5'd0) rd2 = (wr_en && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
    end

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_op     = 2'b00;
        imm_src    = IMM_NONE;
        illegal    = 1'b0;
        case (opcode)
            7'b0000011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 2'b01; end
            7'b0100011: begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
            7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin imm_src = IMM_B; branch = 1'b1; alu_op = 2'b01; end
            7'b0010011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; alu_op = 2'b10; end
            7'b1101111: begin reg_write = 1'b1; imm_src = IMM_J; result_src = 2'b10; jump = 1'b1; end
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (opcode[5] && instrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I: imm = {{(WORD_WIDTH-12){instrD[31]}}, instrD[31:20]};
            IMM_S: imm = {{(WORD_WIDTH-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
            IMM_B: imm = {{(WORD_WIDTH-12){instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            IMM_J: imm = {{(WORD_WIDTH-20){instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // An illegal instruction clears every control field; data fields pass through.
    always_comb begin
        logic bad;
        bad = illegal || (alu_op == 2'b10 && !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}));
        idex_d             = '0;
        idex_d.illegal     = bad;
        idex_d.reg_write   = reg_write & ~bad;
        idex_d.mem_write   = mem_write & ~bad;
        idex_d.jump        = jump & ~bad;
        idex_d.branch      = branch & ~bad;
        idex_d.alu_src     = alu_src & ~bad;
        idex_d.result_src  = bad ? 2'b00 : result_src;
        idex_d.alu_control = bad ? 3'b000 : alu_control;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm         = imm;
        idex_d.pc          = PCD;
        idex_d.pc4         = PCPlus4D;
        idex_d.rs1         = Rs1D;
        idex_d.rs2         = Rs2D;
        idex_d.rd          = instrD[11:7];
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) idex_q <= '0;
        else                 idex_q <= idex_d;
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign IllegalE    = idex_q.illegal;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_control;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrD, PCD, PCPlus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

    int n_vec  = 0;
    int n_miss = 0;

    instruction_decode #(.WORD_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present inputs, then sample 1ns after the next rising edge.
    task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                         input logic rw, input logic [4:0] rdw, input logic [31:0] resw);
        instrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        FlushE    = flush;
        RegWriteW = rw;
        RdW       = rdw;
        ResultW   = resw;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".ctrl"}, {26'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE}, 32'd0);
        check({tag, ".resalu"}, {27'd0, ResultSrcE, ALUControlE}, 32'd0);
        check({tag, ".rd1"}, RD1E, 32'd0);
        check({tag, ".rd2"}, RD2E, 32'd0);
        check({tag, ".imm"}, ImmExtE, 32'd0);
        check({tag, ".pc"}, PCE, 32'd0);
        check({tag, ".pc4"}, PCPlus4E, 32'd0);
        check({tag, ".idx"}, {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        apply(32'h005281B3, 32'h40, 1'b0, 1'b1, 5'd5, 32'h11111111);
        apply(32'h005281B3, 32'h44, 1'b0, 1'b1, 5'd5, 32'h11111111);
        check_bubble("reset");
        reset = 1'b0;

        for (int r = 1; r < 32; r++) begin
            logic [31:0] ins;
            ins = (32'(r) << 20) | (32'(r) << 15) | (32'd1 << 7) | 32'h33;
            apply(ins, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            check($sformatf("rf_clear_x%0d", r), RD1E | RD2E, 32'd0);
        end

        apply(32'h005281B3, 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("bypass.rd1", RD1E, 32'hDEADBEEF);
        check("bypass.rd2", RD2E, 32'hDEADBEEF);
        check("bypass.rd", 32'(RdE), 32'd3);
        check("bypass.alu", 32'(ALUControlE), 32'd0);
        check("bypass.regwr", 32'(RegWriteE), 32'd1);
        check("bypass.rs1e", 32'(Rs1E), 32'd5);
        check("bypass.rs2e", 32'(Rs2E), 32'd5);
        check("bypass.pc", PCE, 32'h100);
        check("bypass.pc4", PCPlus4E, 32'h104);
        check("bypass.imm", ImmExtE, 32'd0);
        check("bypass.alusrc", 32'(ALUSrcE), 32'd0);
        check("rs1d", 32'(Rs1D), 32'd5);
        check("rs2d", 32'(Rs2D), 32'd5);

        apply(32'h005281B3, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0);
        check("stored.x5", RD1E, 32'hDEADBEEF);

        apply(32'h000001B3, 32'h108, 1'b0, 1'b1, 5'd0, 32'h1234);
        check("x0_bypass", RD1E, 32'd0);
        apply(32'h000001B3, 32'h10C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("x0_read", RD1E, 32'd0);

        apply(32'hFFC0A103, 32'h110, 1'b0, 1'b0, 5'd0, 32'h0);
        check("lw.imm", ImmExtE, 32'hFFFFFFFC);
        check("lw.ressrc", 32'(ResultSrcE), 32'd1);
        check("lw.alusrc", 32'(ALUSrcE), 32'd1);
        check("lw.regwr", 32'(RegWriteE), 32'd1);
        check("lw.memwr", 32'(MemWriteE), 32'd0);
        check("lw.rd", 32'(RdE), 32'd2);
        check("lw.illegal", 32'(IllegalE), 32'd0);

        apply(32'h0050A423, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sw.imm", ImmExtE, 32'h8);
        check("sw.memwr", 32'(MemWriteE), 32'd1);
        check("sw.regwr", 32'(RegWriteE), 32'd0);
        check("sw.rd2", RD2E, 32'hDEADBEEF);

        apply(32'hFE000CE3, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0);
        check("beq.imm", ImmExtE, 32'hFFFFFFF8);
        check("beq.branch", 32'(BranchE), 32'd1);
        check("beq.alu", 32'(ALUControlE), 32'd1);
        check("beq.regwr", 32'(RegWriteE), 32'd0);

        apply(32'hFFF00313, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("addi.imm", ImmExtE, 32'hFFFFFFFF);
        check("addi.alu", 32'(ALUControlE), 32'd0);
        check("addi.alusrc", 32'(ALUSrcE), 32'd1);

        apply(32'h405283B3, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sub.alu", 32'(ALUControlE), 32'd1);
        apply(32'h0052A3B3, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0);
        check("slt.alu", 32'(ALUControlE), 32'd5);
        apply(32'h0052E3B3, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0);
        check("or.alu", 32'(ALUControlE), 32'd3);
        apply(32'h0052F3B3, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("and.alu", 32'(ALUControlE), 32'd2);

        apply(32'h005293B3, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0);
        check("badf3.illegal", 32'(IllegalE), 32'd1);
        check("badf3.regwr", 32'(RegWriteE), 32'd0);
        check("badf3.rd1", RD1E, 32'hDEADBEEF);
        check("badf3.rd", 32'(RdE), 32'd7);

        apply(32'h001000EF, 32'h134, 1'b0, 1'b0, 5'd0, 32'h0);
        check("jal.imm", ImmExtE, 32'h800);
        check("jal.jump", 32'(JumpE), 32'd1);
        check("jal.ressrc", 32'(ResultSrcE), 32'd2);
        check("jal.regwr", 32'(RegWriteE), 32'd1);
        check("jal.rd", 32'(RdE), 32'd1);

        apply(32'h001000EF, 32'h138, 1'b1, 1'b1, 5'd9, 32'hCAFEF00D);
        check_bubble("flush");
        apply(32'h000481B3, 32'h13C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("flush_write.x9", RD1E, 32'hCAFEF00D);

        apply(32'hFFFFFFFF, 32'h140, 1'b0, 1'b0, 5'd0, 32'h0);
        check("illegal.flag", 32'(IllegalE), 32'd1);
        check("illegal.ctrl", {28'd0, RegWriteE, MemWriteE, BranchE, JumpE}, 32'd0);
        check("illegal.rd", 32'(RdE), 32'd31);
        check("illegal.pc", PCE, 32'h140);

        reset = 1'b1;
        apply(32'h005281B3, 32'h144, 1'b1, 1'b0, 5'd0, 32'h0);
        check_bubble("reset_flush");
        reset = 1'b0;
        apply(32'h005281B3, 32'h148, 1'b0, 1'b0, 5'd0, 32'h0);
        check("post_reset.x5", RD1E, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
